// File: rtl/conv_output_writer.sv
// Packs per-column convolution result bits into one word per row and writes it to the output SRAM.
// Optional end-of-frame marker word enabled by defining CONV_OUTWR_MARKER_EN.
module conv_output_writer #(
  parameter int unsigned       DATA_W    = 16,
  parameter int unsigned       ADDR_W    = 12,
  parameter logic [ADDR_W-1:0] ADDR_INIT = '0,
  parameter logic [DATA_W-1:0] MARKER    = DATA_W'(16'h00FF)
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              clr_addr,
  input  logic              res_valid,
  input  logic              res_bit,
  input  logic [4:0]        res_col,
  input  logic              row_done,
  input  logic              frame_done,
  output logic              dut_sram_write_enable,
  output logic [ADDR_W-1:0] dut_sram_write_address,
  output logic [DATA_W-1:0] dut_sram_write_data,
  output logic              writer_busy,
  output logic [7:0]        rows_written,
  output logic              err
);

`ifdef CONV_OUTWR_MARKER_EN
  typedef enum logic [1:0] {StIdle, StWr, StMk} state_e;
`else
  typedef enum logic [0:0] {StIdle, StWr} state_e;
`endif

  state_e            state_q, state_d;
  logic [DATA_W-1:0] acc_q, acc_d, acc_m;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        rows_q, rows_d;
  logic              we_q, we_d;
  logic              pend_q, pend_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic              col_ok;
  logic              start_wr;
  logic              overrun;

`ifdef CONV_OUTWR_MARKER_EN
  logic frame_q, frame_d;
`else
  logic              unused_frame_done;
  logic [DATA_W-1:0] unused_marker;
  assign unused_frame_done = frame_done;
  assign unused_marker     = MARKER;
`endif

  assign col_ok = 32'(res_col) < DATA_W;

  always_comb begin
    acc_m = acc_q;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      if (res_valid && col_ok && (32'(res_col) == i)) acc_m[i] = res_bit;
    end
    // A bit presented alongside row_done belongs to the row being committed.
    acc_d  = row_done ? '0 : acc_m;
    hold_d = row_done ? acc_m : hold_q;

    state_d  = state_q;
    we_d     = 1'b0;
    data_d   = data_q;
    pend_d   = pend_q;
    start_wr = row_done || pend_q;

    unique case (state_q)
      StIdle: begin
        if (start_wr) begin
          state_d = StWr;
          we_d    = 1'b1;
          data_d  = hold_d;
          pend_d  = 1'b0;
        end
`ifdef CONV_OUTWR_MARKER_EN
        else if (frame_q || frame_done) begin
          state_d = StMk;
          we_d    = 1'b1;
          data_d  = MARKER;
        end
`endif
      end
      StWr: begin
`ifdef CONV_OUTWR_MARKER_EN
        if (frame_q || frame_done) begin
          state_d = StMk;
          we_d    = 1'b1;
          data_d  = MARKER;
          pend_d  = pend_q | row_done;
        end else
`endif
        if (start_wr) begin
          state_d = StWr;
          we_d    = 1'b1;
          data_d  = hold_d;
          pend_d  = 1'b0;
        end else begin
          state_d = StIdle;
        end
      end
`ifdef CONV_OUTWR_MARKER_EN
      StMk: begin
        state_d = StIdle;
        pend_d  = pend_q | row_done;
      end
`endif
      default: state_d = StIdle;
    endcase

`ifdef CONV_OUTWR_MARKER_EN
    frame_d = (state_d == StMk) ? 1'b0 : (frame_q | frame_done);
    busy_d  = (state_d != StIdle) | pend_d | frame_d;
`else
    busy_d  = (state_d != StIdle) | pend_d;
`endif

    // A second row arrived before the pending one could be written.
    overrun = row_done && pend_q && (state_q != StIdle);

    if (clr_addr) begin
      addr_d = ADDR_INIT;
      rows_d = '0;
      err_d  = 1'b0;
    end else begin
      addr_d = (state_q != StIdle) ? addr_q + ADDR_W'(1) : addr_q;
      rows_d = (state_q == StWr) ? rows_q + 8'd1 : rows_q;
      err_d  = err_q | (res_valid && !col_ok) | overrun;
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q <= StIdle;
      acc_q   <= '0;
      hold_q  <= '0;
      data_q  <= '0;
      addr_q  <= ADDR_INIT;
      rows_q  <= '0;
      we_q    <= 1'b0;
      pend_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      hold_q  <= hold_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      rows_q  <= rows_d;
      we_q    <= we_d;
      pend_q  <= pend_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

`ifdef CONV_OUTWR_MARKER_EN
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) frame_q <= 1'b0;
    else          frame_q <= frame_d;
  end
`endif

  assign dut_sram_write_enable  = we_q;
  assign dut_sram_write_address = addr_q;
  assign dut_sram_write_data    = data_q;
  assign writer_busy            = busy_q;
  assign rows_written           = rows_q;
  assign err                    = err_q;

endmodule

// File: tb/tb_conv_output_writer.sv
// Scoreboard bench for conv_output_writer: expected writes are queued by the stimulus and
// consumed by a monitor that sees each SRAM write strobe.
module tb_conv_output_writer;

  logic        clk = 1'b0;
  logic        reset_b = 1'b0;
  logic        clr_addr = 1'b0;
  logic        res_valid = 1'b0;
  logic        res_bit = 1'b0;
  logic [4:0]  res_col = '0;
  logic        row_done = 1'b0;
  logic        frame_done = 1'b0;
  logic        we;
  logic [11:0] addr;
  logic [15:0] data;
  logic        busy;
  logic [7:0]  rows;
  logic        err;

  conv_output_writer dut (
    .clk                    (clk),
    .reset_b                (reset_b),
    .clr_addr               (clr_addr),
    .res_valid              (res_valid),
    .res_bit                (res_bit),
    .res_col                (res_col),
    .row_done               (row_done),
    .frame_done             (frame_done),
    .dut_sram_write_enable  (we),
    .dut_sram_write_address (addr),
    .dut_sram_write_data    (data),
    .writer_busy            (busy),
    .rows_written           (rows),
    .err                    (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [11:0] addr;
    logic [15:0] data;
    int          cyc;
  } wr_t;

  wr_t         exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [15:0] m_acc = '0;
  logic [11:0] exp_addr = '0;
  logic [7:0]  exp_rows = '0;
  int          last_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every write strobe must match the oldest queued expectation.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (we === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: got addr %0h data %0h, required no write", addr, data);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", 32'(addr), 32'(e.addr));
          check("wr_data", 32'(data), 32'(e.data));
          check("wr_cycle", cyc, e.cyc);
        end
      end
    end
  end

  task automatic drive(input logic rv, input logic [4:0] col, input logic b,
                       input logic rd, input logic fd, input logic ca);
    @(negedge clk);
    res_valid  = rv;
    res_col    = col;
    res_bit    = b;
    row_done   = rd;
    frame_done = fd;
    clr_addr   = ca;
  endtask

  task automatic put_bit(input int col, input logic b);
    drive(1'b1, 5'(col), b, 1'b0, 1'b0, 1'b0);
    if (col < 16) m_acc[col] = b;
  endtask

  task automatic push_row();
    exp_q.push_back('{addr: exp_addr, data: m_acc, cyc: cyc + 1});
    last_cyc = cyc + 1;
    exp_addr = exp_addr + 12'd1;
    exp_rows = exp_rows + 8'd1;
    m_acc    = '0;
  endtask

  task automatic row();
    drive(1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    push_row();
  endtask

  task automatic row_bit(input int col, input logic b);
    drive(1'b1, 5'(col), b, 1'b1, 1'b0, 1'b0);
    if (col < 16) m_acc[col] = b;
    push_row();
  endtask

  task automatic frame();
    drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
`ifdef CONV_OUTWR_MARKER_EN
    exp_q.push_back('{addr: exp_addr, data: 16'h00FF,
                      cyc: (cyc + 1 > last_cyc + 1) ? cyc + 1 : last_cyc + 1});
    exp_addr = exp_addr + 12'd1;
`endif
  endtask

  task automatic clr();
    drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    exp_addr = '0;
    exp_rows = '0;
  endtask

  task automatic drain();
    drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_values();
    check("rst_we", 32'(we), 0);
    check("rst_addr", 32'(addr), 0);
    check("rst_data", 32'(data), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_rows", 32'(rows), 0);
    check("rst_err", 32'(err), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check_reset_values();
    reset_b = 1'b1;

    // Single row of alternating bits.
    clr();
    for (int i = 0; i < 14; i++) put_bit(i, (i % 2) == 0);
    row();
    drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("busy_during_write", 32'(busy), 1);
    drain();
    check("rows_after_one", 32'(rows), 32'(exp_rows));
    check("addr_after_one", 32'(addr), 32'(exp_addr));
    check("busy_idle", 32'(busy), 0);

    // Fourteen rows followed by a frame end.
    clr();
    for (int i = 0; i < 14; i++) begin
      put_bit(i, 1'b1);
      put_bit(15, (i % 2) == 1);
      row();
    end
    frame();
    drain();
    check("busy_after_frame", 32'(busy), 0);
    check("rows_after_frame", 32'(rows), 32'(exp_rows));
    check("addr_after_frame", 32'(addr), 32'(exp_addr));

    // Back-to-back rows, the second carrying a bit in its row_done cycle.
    put_bit(1, 1'b1);
    put_bit(4, 1'b1);
    row();
    row_bit(7, 1'b1);
    put_bit(9, 1'b1);
    row();
    drain();
    check("err_back_to_back", 32'(err), 0);

    // Out-of-range column: bit dropped, sticky error until clr_addr.
    put_bit(2, 1'b1);
    put_bit(20, 1'b1);
    drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("err_bad_col", 32'(err), 1);
    row();
    drain();
    check("err_sticky", 32'(err), 1);
    clr();
    drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("err_cleared", 32'(err), 0);
    check("addr_cleared", 32'(addr), 0);
    check("rows_cleared", 32'(rows), 0);

    // Address wrap: advance to 0xFFF, then two rows land at 0xFFF and 0x000.
    for (int i = 0; i < 4095; i++) row();
    drain();
    check("addr_at_top", 32'(addr), 32'h0FFF);
    row_bit(3, 1'b1);
    row_bit(9, 1'b1);
    drain();
    check("addr_wrapped", 32'(addr), 32'(exp_addr));
    check("rows_wrapped", 32'(rows), 32'(exp_rows));
    check("err_after_wrap", 32'(err), 0);

    // Reset asserted in the cycle the write strobe would rise.
    put_bit(5, 1'b1);
    @(negedge clk);
    res_valid = 1'b0;
    row_done  = 1'b1;
    reset_b   = 1'b0;
    @(negedge clk);
    row_done = 1'b0;
    check_reset_values();
    reset_b  = 1'b1;
    m_acc    = '0;
    exp_addr = '0;
    exp_rows = '0;
    put_bit(0, 1'b1);
    row();
    drain();
    check("rows_after_reset_row", 32'(rows), 32'(exp_rows));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
